// File: rtl/request_arbiter.sv
// Round-robin arbiter: one-entry holding slot per requester, drained into a shared FIFO.
// Optional macro REQ_ARB_STAMP_EN overwrites the top index bits of fifo_data with the granted source.
module request_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         write_req,
  input  logic [N_REQ*DATA_W-1:0]  dataIn_req,
  output logic [N_REQ-1:0]         full_req,
  output logic [N_REQ-1:0]         almost_full_req,
  output logic [N_REQ-1:0]         ovf_req,
  input  logic                     fifo_full,
  input  logic                     fifo_almost_full,
  output logic [DATA_W-1:0]        fifo_data,
  output logic                     fifo_write
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]  slot_v;
  logic [DATA_W-1:0] slot_d [N_REQ];
  logic [N_REQ-1:0]  slot_clr;

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] fifo_data_q, fifo_data_d;
  logic              fifo_write_q, fifo_write_d;

  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_v;
  logic              grant_en;
  logic              grant_fire;

  // Hold off while the FIFO could be filled by the write already issued last cycle.
  assign grant_en   = !fifo_full && !(fifo_almost_full && fifo_write_q);
  assign grant_fire = grant_en && gnt_v;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : gen_slot
      logic              valid_q;
      logic [DATA_W-1:0] data_q;
      logic              ovf_q;

      assign slot_clr[gi] = grant_fire && (gnt_idx == IDX_W'(gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          ovf_q   <= 1'b0;
        end else begin
          if (write_req[gi] && !valid_q) begin
            valid_q <= 1'b1;
            data_q  <= dataIn_req[gi*DATA_W +: DATA_W];
          end else if (slot_clr[gi]) begin
            valid_q <= 1'b0;
          end
          if (write_req[gi] && valid_q) begin
            ovf_q <= 1'b1;
          end
        end
      end

      assign slot_v[gi]          = valid_q;
      assign slot_d[gi]          = data_q;
      assign ovf_req[gi]         = ovf_q;
      assign full_req[gi]        = valid_q;
      assign almost_full_req[gi] = valid_q | fifo_almost_full;
    end
  endgenerate

  // First occupied slot scanning upward from rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    logic [IDX_W:0] cand;
    gnt_idx = '0;
    gnt_v   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!gnt_v && slot_v[cand[IDX_W-1:0]]) begin
        gnt_v   = 1'b1;
        gnt_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    fifo_data_d  = fifo_data_q;
    fifo_write_d = 1'b0;
    if (grant_fire) begin
      fifo_write_d = 1'b1;
      fifo_data_d  = slot_d[gnt_idx];
`ifdef REQ_ARB_STAMP_EN
      fifo_data_d[DATA_W-1 -: IDX_W] = gnt_idx;
`endif
      rr_ptr_d = (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      fifo_data_q  <= '0;
      fifo_write_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      fifo_data_q  <= fifo_data_d;
      fifo_write_q <= fifo_write_d;
    end
  end

  assign fifo_data  = fifo_data_q;
  assign fifo_write = fifo_write_q;

endmodule
